// File: rtl/csr_rmw_stage.sv
// CSRRW/RS/RC read-modify-write stage in front of the CSR store: old value read at accept, write one cycle later, old value on a registered response.
// Accept->write 1 cycle, accept->rsp 2 cycles; S1 and its write stall behind an unaccepted response. CSR_FWD_EN forwards S1's pending value instead of bubbling.
module csr_rmw_stage #(
   parameter  int NUM_WARPS = 4,
   parameter  int ADDR_BITS = 12,
   parameter  int RD_BITS   = 5,
   localparam int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [NW_BITS-1:0]   req_wid,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [1:0]           req_op,
   input  logic                 req_use_imm,
   input  logic [4:0]           req_imm,
   input  logic [31:0]          req_rs1_data,
   input  logic [RD_BITS-1:0]   req_rd,
   output logic                 csr_read_enable,
   output logic [ADDR_BITS-1:0] csr_read_addr,
   output logic [NW_BITS-1:0]   csr_read_wid,
   input  logic [31:0]          csr_read_data,
   output logic                 csr_write_enable,
   output logic [ADDR_BITS-1:0] csr_write_addr,
   output logic [NW_BITS-1:0]   csr_write_wid,
   output logic [31:0]          csr_write_data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [NW_BITS-1:0]   rsp_wid,
   output logic [RD_BITS-1:0]   rsp_rd,
   output logic [31:0]          rsp_data,
   output logic                 rsp_illegal,
   output logic                 busy
);

   typedef enum logic [1:0] {
      OP_ILL = 2'd0,
      OP_RW  = 2'd1,
      OP_RS  = 2'd2,
      OP_RC  = 2'd3
   } op_e;

   typedef struct packed {
      logic                 vld;
      logic [NW_BITS-1:0]   wid;
      logic [ADDR_BITS-1:0] addr;
      logic [RD_BITS-1:0]   rd;
      logic [31:0]          old;
      logic [31:0]          nxt;
      logic                 wr;
      logic                 ill;
   } s1_t;

   typedef struct packed {
      logic                 vld;
      logic [NW_BITS-1:0]   wid;
      logic [RD_BITS-1:0]   rd;
      logic [31:0]          data;
      logic                 ill;
   } rsp_t;

   s1_t  s1_q, s1_d;
   rsp_t r_q, r_d;

   logic        advance;
   logic        s1_go;
   logic        hazard;
   logic        req_fire;
   logic [31:0] operand;
   logic [31:0] old_val;
   logic [31:0] new_val;
   logic        wr_need;
   logic        read_only;
   logic        ill;

   always_comb begin
      advance = ~r_q.vld | rsp_ready;
      s1_go   = s1_q.vld & advance;
      // Only a write that will actually land can make the store's read stale
      hazard  = s1_q.vld & s1_q.wr & (req_addr == s1_q.addr) & (req_wid == s1_q.wid);
`ifdef CSR_FWD_EN
      req_ready = ~reset & (~s1_q.vld | advance);
      old_val   = hazard ? s1_q.nxt : csr_read_data;
`else
      req_ready = ~reset & (~s1_q.vld | advance) & ~hazard;
      old_val   = csr_read_data;
`endif
      req_fire = req_valid & req_ready;
      operand  = req_use_imm ? {27'd0, req_imm} : req_rs1_data;

      wr_need = 1'b0;
      new_val = old_val;
      case (req_op)
         OP_RW: begin
            new_val = operand;
            wr_need = 1'b1;
         end
         OP_RS: begin
            new_val = old_val | operand;
            wr_need = |operand;
         end
         OP_RC: begin
            new_val = old_val & ~operand;
            wr_need = |operand;
         end
         default: ;
      endcase
      read_only = (req_addr[ADDR_BITS-1 -: 2] == 2'b11);
      ill       = (req_op == OP_ILL) | (read_only & wr_need);

      s1_d = s1_q;
      if (req_fire) begin
         s1_d.vld  = 1'b1;
         s1_d.wid  = req_wid;
         s1_d.addr = req_addr;
         s1_d.rd   = req_rd;
         s1_d.old  = old_val;
         s1_d.nxt  = new_val;
         s1_d.wr   = wr_need & ~ill;
         s1_d.ill  = ill;
      end else if (s1_go) begin
         s1_d.vld = 1'b0;
      end

      r_d = r_q;
      if (s1_go) begin
         r_d.vld  = 1'b1;
         r_d.wid  = s1_q.wid;
         r_d.rd   = s1_q.rd;
         r_d.data = s1_q.old;
         r_d.ill  = s1_q.ill;
      end else if (rsp_ready) begin
         r_d.vld = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= '0;
         r_q  <= '0;
      end else begin
         s1_q <= s1_d;
         r_q  <= r_d;
      end
   end

   assign csr_read_enable  = req_fire;
   assign csr_read_addr    = req_addr;
   assign csr_read_wid     = req_wid;

   // Gating with reset drops an in-flight entry without touching the store
   assign csr_write_enable = ~reset & s1_go & s1_q.wr;
   assign csr_write_addr   = csr_write_enable ? s1_q.addr : '0;
   assign csr_write_wid    = csr_write_enable ? s1_q.wid  : '0;
   assign csr_write_data   = csr_write_enable ? s1_q.nxt  : '0;

   assign rsp_valid   = r_q.vld;
   assign rsp_wid     = r_q.wid;
   assign rsp_rd      = r_q.rd;
   assign rsp_data    = r_q.data;
   assign rsp_illegal = r_q.ill;
   assign busy        = s1_q.vld | r_q.vld;

endmodule

// File: tb/tb_csr_rmw_stage.sv
// Bench for csr_rmw_stage: directed vector table, hazard/stall/reset sequences, then random traffic against an in-order CSR model.
module tb_csr_rmw_stage;
   localparam int NUM_WARPS = 4;
   localparam int ADDR_BITS = 12;
   localparam int RD_BITS   = 5;
   localparam int NW_BITS   = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 req_valid;
   logic                 req_ready;
   logic [NW_BITS-1:0]   req_wid;
   logic [ADDR_BITS-1:0] req_addr;
   logic [1:0]           req_op;
   logic                 req_use_imm;
   logic [4:0]           req_imm;
   logic [31:0]          req_rs1_data;
   logic [RD_BITS-1:0]   req_rd;
   logic                 csr_read_enable;
   logic [ADDR_BITS-1:0] csr_read_addr;
   logic [NW_BITS-1:0]   csr_read_wid;
   logic [31:0]          csr_read_data;
   logic                 csr_write_enable;
   logic [ADDR_BITS-1:0] csr_write_addr;
   logic [NW_BITS-1:0]   csr_write_wid;
   logic [31:0]          csr_write_data;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [NW_BITS-1:0]   rsp_wid;
   logic [RD_BITS-1:0]   rsp_rd;
   logic [31:0]          rsp_data;
   logic                 rsp_illegal;
   logic                 busy;

   always #5 clk = ~clk;

   csr_rmw_stage #(.NUM_WARPS(NUM_WARPS), .ADDR_BITS(ADDR_BITS), .RD_BITS(RD_BITS)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_addr(req_addr),
      .req_op(req_op), .req_use_imm(req_use_imm), .req_imm(req_imm), .req_rs1_data(req_rs1_data),
      .req_rd(req_rd),
      .csr_read_enable(csr_read_enable), .csr_read_addr(csr_read_addr), .csr_read_wid(csr_read_wid),
      .csr_read_data(csr_read_data),
      .csr_write_enable(csr_write_enable), .csr_write_addr(csr_write_addr),
      .csr_write_wid(csr_write_wid), .csr_write_data(csr_write_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid), .rsp_rd(rsp_rd),
      .rsp_data(rsp_data), .rsp_illegal(rsp_illegal), .busy(busy)
   );

   // CSR store the DUT talks to; preload port lets the bench seed values
   logic [31:0] store [0:16383];
   logic        st_clr = 1'b1;
   logic        pre_en = 1'b0;
   logic [13:0] pre_idx = '0;
   logic [31:0] pre_dat = '0;

   always @(posedge clk) begin
      if (st_clr) begin
         for (int i = 0; i < 16384; i++) store[i] <= '0;
      end else if (pre_en) begin
         store[pre_idx] <= pre_dat;
      end else if (csr_write_enable) begin
         store[{csr_write_wid, csr_write_addr}] <= csr_write_data;
      end
   end
   assign csr_read_data = store[{csr_read_wid, csr_read_addr}];

   typedef struct {
      logic [1:0]  op;
      logic        use_imm;
      logic [4:0]  imm;
      logic [31:0] rs1;
      logic [11:0] addr;
      logic [1:0]  wid;
      logic [4:0]  rd;
   } req_t;
   typedef struct { logic [1:0] wid; logic [11:0] addr; logic [31:0] data; } wr_t;
   typedef struct { logic [1:0] wid; logic [4:0] rd; logic [31:0] data; logic ill; } rsp_t;
   typedef struct {
      req_t        r;
      logic [31:0] init;
      logic        exp_wr;
      logic [31:0] exp_wdat;
      logic        exp_ill;
   } vec_t;

   logic [31:0] mdl [0:16383];
   req_t req_q[$];
   wr_t  exp_wr_q[$];
   rsp_t exp_rsp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   outstanding = 0;
   int   n_writes = 0;
   int   gap_pct = 0;
   int   rr_pct = 100;
   logic last_fire = 1'b0;
   logic last_wr = 1'b0;
   logic hold_prev = 1'b0;
   rsp_t prev_rsp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Sequential CSR semantics: every accepted instruction sees all earlier writes
   task automatic model_accept(input req_t r);
      logic [31:0] opnd, old, nv;
      logic        wr, ill;
      logic [13:0] idx;
      idx  = {r.wid, r.addr};
      old  = mdl[idx];
      opnd = r.use_imm ? 32'(r.imm) : r.rs1;
      wr   = 1'b0;
      ill  = 1'b0;
      nv   = old;
      case (r.op)
         2'd1: begin nv = opnd;        wr = 1'b1;        end
         2'd2: begin nv = old | opnd;  wr = (opnd != 0); end
         2'd3: begin nv = old & ~opnd; wr = (opnd != 0); end
         default: ill = 1'b1;
      endcase
      if (wr && r.addr[11:10] == 2'b11) begin
         wr  = 1'b0;
         ill = 1'b1;
      end
      if (wr) begin
         mdl[idx] = nv;
         exp_wr_q.push_back('{r.wid, r.addr, nv});
      end
      exp_rsp_q.push_back('{r.wid, r.rd, old, ill});
   endtask

   task automatic sample();
      bit match;
      chk("busy", busy, outstanding > 0);
      if (hold_prev) begin
         chk("rsp_hold_valid", rsp_valid, 1);
         chk("rsp_hold_data", rsp_data, prev_rsp.data);
         chk("rsp_hold_fields", {rsp_illegal, rsp_rd, rsp_wid}, {prev_rsp.ill, prev_rsp.rd, prev_rsp.wid});
      end
`ifndef CSR_FWD_EN
      if (req_valid) begin
         match = 0;
         foreach (exp_wr_q[i]) if (exp_wr_q[i].addr == req_addr && exp_wr_q[i].wid == req_wid) match = 1;
         if (match) chk("hazard_bubble", req_ready, 0);
      end
`endif
      last_wr = csr_write_enable;
      if (csr_write_enable) begin
         n_writes++;
         if (exp_wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", csr_write_addr, csr_write_data);
         end else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            chk("wr_addr", {csr_write_wid, csr_write_addr}, {e.wid, e.addr});
            chk("wr_data", csr_write_data, e.data);
         end
      end else begin
         chk("wr_idle_zero", csr_write_data | 32'(csr_write_addr) | 32'(csr_write_wid), 0);
      end
      if (rsp_valid && rsp_ready) begin
         outstanding--;
         if (exp_rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: data 0x%0h, none expected", rsp_data);
         end else begin
            rsp_t e;
            e = exp_rsp_q.pop_front();
            chk("rsp_wid", rsp_wid, e.wid);
            chk("rsp_rd", rsp_rd, e.rd);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_illegal", rsp_illegal, e.ill);
         end
      end
      hold_prev = rsp_valid & ~rsp_ready;
      prev_rsp  = '{rsp_wid, rsp_rd, rsp_data, rsp_illegal};
      last_fire = req_valid & req_ready;
      if (last_fire && req_q.size() > 0) begin
         chk("rd_en", csr_read_enable, 1);
         chk("rd_addr", {csr_read_wid, csr_read_addr}, {req_wid, req_addr});
         model_accept(req_q.pop_front());
         outstanding++;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      pre_en = 1'b0;
      if (req_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
         req_valid    = 1'b1;
         req_op       = req_q[0].op;
         req_use_imm  = req_q[0].use_imm;
         req_imm      = req_q[0].imm;
         req_rs1_data = req_q[0].rs1;
         req_addr     = req_q[0].addr;
         req_wid      = req_q[0].wid;
         req_rd       = req_q[0].rd;
      end else begin
         req_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(99) < rr_pct);
      @(negedge clk);
      sample();
   endtask

   task automatic preload(input logic [1:0] w, input logic [11:0] a, input logic [31:0] d);
      mdl[{w, a}] = d;
      pre_idx = {w, a};
      pre_dat = d;
      pre_en  = 1'b1;
      cycle();
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while ((req_q.size() > 0 || busy) && c < 5000) begin
         cycle();
         c++;
      end
      chk({name, "_drained"}, busy | (req_q.size() != 0), 0);
      chk({name, "_wr_q_empty"}, exp_wr_q.size(), 0);
      chk({name, "_rsp_q_empty"}, exp_rsp_q.size(), 0);
   endtask

   vec_t        vt[8];
   logic [11:0] addr_set[4];
   int          wr0;

   initial begin
      vt[0] = '{'{2'd1, 1'b0, 5'd0,  32'h8, 12'h300, 2'd1, 5'd3}, 32'h0,    1'b1, 32'h8,   1'b0};
      vt[1] = '{'{2'd2, 1'b1, 5'd0,  32'h0, 12'h001, 2'd0, 5'd4}, 32'h1F,   1'b0, 32'h0,   1'b0};
      vt[2] = '{'{2'd3, 1'b0, 5'd0,  32'h3, 12'h300, 2'd0, 5'd5}, 32'hF,    1'b1, 32'hC,   1'b0};
      vt[3] = '{'{2'd2, 1'b0, 5'd0,  32'h1, 12'hF14, 2'd2, 5'd6}, 32'hABCD, 1'b0, 32'h0,   1'b1};
      vt[4] = '{'{2'd2, 1'b1, 5'h11, 32'h0, 12'h300, 2'd3, 5'd7}, 32'h100,  1'b1, 32'h111, 1'b0};
      vt[5] = '{'{2'd0, 1'b0, 5'd0,  32'h5, 12'h300, 2'd0, 5'd8}, 32'h77,   1'b0, 32'h0,   1'b1};
      vt[6] = '{'{2'd1, 1'b0, 5'd0,  32'h0, 12'hC00, 2'd1, 5'd9}, 32'h42,   1'b0, 32'h0,   1'b1};
      vt[7] = '{'{2'd3, 1'b0, 5'd0,  32'h0, 12'hF14, 2'd0, 5'd10}, 32'h99,  1'b0, 32'h0,   1'b0};
      addr_set = '{12'h300, 12'h301, 12'hF14, 12'hC02};
      for (int i = 0; i < 16384; i++) mdl[i] = '0;

      // Reset with a request held valid: nothing may be accepted or read
      reset = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op = 2'd1; req_use_imm = 1'b0; req_imm = '0; req_rs1_data = 32'h1;
      req_addr = 12'h300; req_wid = 2'd0; req_rd = 5'd1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", req_ready, 0);
      chk("reset_rd_en", csr_read_enable, 0);
      chk("reset_wr_en", csr_write_enable, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_rsp_fields", {rsp_illegal, rsp_rd, rsp_wid}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      st_clr = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);

      foreach (vt[i]) begin
         preload(vt[i].r.wid, vt[i].r.addr, vt[i].init);
         req_q.push_back(vt[i].r);
         cycle();
         chk("tbl_accept", last_fire, 1);
         cycle();
         chk("tbl_wr_en", last_wr, vt[i].exp_wr);
         if (vt[i].exp_wr) chk("tbl_wr_data", csr_write_data, vt[i].exp_wdat);
         chk("tbl_rsp_early", rsp_valid, 0);
         cycle();
         chk("tbl_rsp_valid", rsp_valid, 1);
         chk("tbl_rsp_data", rsp_data, vt[i].init);
         chk("tbl_rsp_ill", rsp_illegal, vt[i].exp_ill);
      end
      drain("tbl");

      // Back-to-back same CSR: second must observe the first's value
      preload(2'd0, 12'h300, 32'h0);
      req_q.push_back('{2'd1, 1'b0, 5'd0, 32'h5, 12'h300, 2'd0, 5'd1});
      req_q.push_back('{2'd2, 1'b0, 5'd0, 32'h2, 12'h300, 2'd0, 5'd2});
      cycle();
      chk("hz_first_accept", last_fire, 1);
      cycle();
`ifdef CSR_FWD_EN
      chk("hz_fwd_no_bubble", last_fire, 1);
`else
      chk("hz_bubble", last_fire, 0);
      chk("hz_first_write", last_wr, 1);
      cycle();
      chk("hz_second_accept", last_fire, 1);
      chk("hz_read_new", csr_read_data, 32'h5);
`endif
      cycle();
      chk("hz_second_write", last_wr, 1);
      chk("hz_second_data", csr_write_data, 32'h7);
      drain("hz");

      // Response held off for 5 cycles with three requests queued
      rr_pct = 0;
      req_q.push_back('{2'd1, 1'b0, 5'd0, 32'h11, 12'h301, 2'd1, 5'd11});
      req_q.push_back('{2'd1, 1'b0, 5'd0, 32'h22, 12'h302, 2'd1, 5'd12});
      req_q.push_back('{2'd1, 1'b0, 5'd0, 32'h33, 12'h303, 2'd1, 5'd13});
      wr0 = n_writes;
      for (int i = 0; i < 5; i++) cycle();
      chk("stall_one_write", n_writes - wr0, 1);
      chk("stall_third_blocked", req_q.size(), 1);
      chk("stall_rsp_valid", rsp_valid, 1);
      rr_pct = 100;
      drain("stall");
      chk("stall_total_writes", n_writes - wr0, 3);

      // Reset with S1 occupied: the pending write must vanish
      preload(2'd2, 12'h300, 32'h1234);
      req_q.push_back('{2'd1, 1'b0, 5'd0, 32'hDEAD, 12'h300, 2'd2, 5'd4});
      cycle();
      chk("rst_accept", last_fire, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      req_valid = 1'b0;
      chk("rst_busy_before", busy, 1);
      @(negedge clk);
      chk("rst_no_write", csr_write_enable, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy_after", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_outputs", {rsp_illegal, csr_write_enable, csr_read_enable}, 0);
      chk("rst_store_kept", store[{2'd2, 12'h300}], 32'h1234);
      mdl[{2'd2, 12'h300}] = 32'h1234;
      exp_wr_q.delete();
      exp_rsp_q.delete();
      outstanding = 0;
      hold_prev = 1'b0;

      // Random traffic on a few hot CSRs to provoke hazards and stalls
      gap_pct = 25;
      rr_pct = 70;
      for (int n = 0; n < 400; n++) begin
         req_t r;
         r.op      = ($urandom_range(15) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
         r.use_imm = 1'($urandom_range(1));
         r.imm     = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
         r.rs1     = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
         r.addr    = addr_set[$urandom_range(3)];
         r.wid     = 2'($urandom_range(1));
         r.rd      = 5'($urandom);
         req_q.push_back(r);
      end
      drain("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
